axis_uart_tx_arbiter: RTL and testbench
=======================================

AXIS_UART_TX_ARBITER -- requirements
Module: axis_uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, the number of AXI-stream requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the beat width, equal on every port.
REQ-003 SHALL have port aclk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port aresetn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port s_tvalid, input, NUM_PORTS, per-requester valid.
REQ-006 SHALL have port s_tlast, input, NUM_PORTS, per-requester end of packet.
REQ-007 SHALL have port s_tdata, input, NUM_PORTS*DATA_WIDTH, requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port s_tready, output, NUM_PORTS, per-requester ready.
REQ-009 SHALL have port m_tvalid, output, 1, merged stream valid to the UART hex transmitter.
REQ-010 SHALL have port m_tlast, output, 1, merged stream end of packet.
REQ-011 SHALL have port m_tdata, output, DATA_WIDTH, merged stream data.
REQ-012 SHALL have port m_tready, input, 1, transmitter ready.
REQ-013 SHALL have port grant_idx, output, 3, index of the current or last granted requester.

Function
REQ-014 SHALL implement FSM states IDLE, TAG (macro only), PKT.
REQ-015 IDLE: when any s_tvalid is high, grant the first requester with valid in round-robin order, starting at last_grant+1 modulo NUM_PORTS; register the grant and enter PKT (TAG if the macro is defined) next cycle.
REQ-016 IDLE: no s_tvalid SHALL keep the FSM in IDLE; s_tready SHALL be all zero in IDLE.
REQ-017 PKT: s_tready[g] = !m_tvalid || m_tready for granted g; every other s_tready bit SHALL be 0.
REQ-018 A beat accepted on port g (s_tvalid[g] & s_tready[g]) SHALL load the output register, giving m_tvalid=1 and m_tdata/m_tlast from port g one cycle later (latency 1).
REQ-019 m_tvalid SHALL clear on m_tready when no new beat loads in the same cycle; a simultaneous drain and load SHALL hold m_tvalid=1 with the new beat (full throughput, 1 beat/cycle).
REQ-020 m_tdata/m_tlast SHALL remain stable while m_tvalid=1 and m_tready=0.
REQ-021 Grant SHALL be packet-granular: an accepted beat with s_tlast[g]=1 SHALL set last_grant=g and return the FSM to IDLE; no other port is served mid-packet.
REQ-022 Requester valid deasserting mid-packet SHALL hold the grant (no timeout); the output register still drains.
REQ-023 Round-robin wrap: after last_grant=NUM_PORTS-1, search SHALL start at port 0.
REQ-024 grant_idx SHALL update when the grant registers and hold through IDLE.

Reset
REQ-025 aresetn low SHALL asynchronously force: FSM=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, grant_idx=0, last_grant=NUM_PORTS-1 (port 0 gets first priority).
REQ-026 Reset mid-packet SHALL discard the packet remainder and any held output beat; no partial state SHALL survive.

Configuration
REQ-027 Macro AXIS_UART_TX_ARB_TAG_EN: when defined, TAG state SHALL emit one header beat before each packet, m_tdata = zero-extended granted index, m_tlast=0, loaded when the output register is free; PKT follows next cycle.
REQ-028 Without AXIS_UART_TX_ARB_TAG_EN: no TAG state, no header beats; IDLE goes directly to PKT.

Verification
REQ-029 Reset, ports 0 and 2 valid with 1-beat packets 0x11111111 and 0x22222222, m_tready=1 -> m_tdata 0x11111111 then 0x22222222, each with m_tlast=1.
REQ-030 Port 1 sends 3-beat packet while port 3 valid from cycle 1 -> all 3 port-1 beats out contiguously, then port 3; s_tready[3]=0 throughout.
REQ-031 m_tready held 0 for 5 cycles with m_tvalid=1 and m_tdata=0xDEADBEEF -> m_tdata stable, s_tready[g]=0, no beat lost after m_tready=1.
REQ-032 All 4 ports continuously valid, 1-beat packets -> grant order 0,1,2,3,0 (wrap).
REQ-033 aresetn pulsed low during beat 2 of a 4-beat packet -> m_tvalid=0 immediately; next grant is port 0.
REQ-034 With AXIS_UART_TX_ARB_TAG_EN, port 2 sends 0xCAFEF00D with tlast -> m_tdata 0x00000002 (tlast 0) then 0xCAFEF00D (tlast 1).

Source files
------------

// File: rtl/axis_uart_tx_arbiter.sv
// axis_uart_tx_arbiter
// Merges NUM_PORTS AXI-stream requesters into one registered stream that
// feeds the UART hex transmitter. Arbitration is round-robin and
// packet-granular: once a requester is granted, it keeps the output until
// its tlast beat has been accepted.
// Optional feature: define AXIS_UART_TX_ARB_TAG_EN to emit one header beat
// (the zero-extended granted index, tlast=0) ahead of every packet.

module axis_uart_tx_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    output logic [NUM_PORTS-1:0]            s_tready,
    output logic                            m_tvalid,
    output logic                            m_tlast,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    input  logic                            m_tready,
    output logic [2:0]                      grant_idx
);

`ifdef AXIS_UART_TX_ARB_TAG_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        PKT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd2
    } state_t;
`endif

    state_t                  state_q;
    state_t                  state_d;
    logic [2:0]              grant_q;
    logic [2:0]              last_grant_q;
    logic [2:0]              pick_idx;
    logic                    pick_found;
    logic [7:0]              valid_pad;
    logic [7:0]              last_pad;
    logic [DATA_WIDTH-1:0]   data_arr [8];
    logic                    out_free;
    logic                    beat_accept;
    logic                    beat_last;
    logic                    tag_load;

    // Port vectors are widened to eight entries so that the 3-bit grant
    // index can select from them for every legal NUM_PORTS.
    assign valid_pad = 8'(s_tvalid);
    assign last_pad  = 8'(s_tlast);

    for (genvar i = 0; i < 8; i++) begin : g_data
        if (i < NUM_PORTS) begin : g_used
            assign data_arr[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign data_arr[i] = '0;
        end
    end

    // Round-robin candidate: the port 'step' positions after 'base'.
    function automatic logic [2:0] rr_next(input logic [2:0] base, input int step);
        int sum;
        sum = (int'(base) + step) % NUM_PORTS;
        return sum[2:0];
    endfunction

    // The output register can take a new beat when empty or draining now.
    assign out_free    = !m_tvalid || m_tready;
    assign beat_accept = (state_q == PKT) && valid_pad[grant_q] && out_free;
    assign beat_last   = last_pad[grant_q];
    assign grant_idx   = grant_q;

`ifdef AXIS_UART_TX_ARB_TAG_EN
    assign tag_load = (state_q == TAG) && out_free;
`else
    assign tag_load = 1'b0;
`endif

    // Find the first valid requester after the last one that finished a packet.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_grant_q;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!pick_found && valid_pad[rr_next(last_grant_q, k)]) begin
                pick_found = 1'b1;
                pick_idx   = rr_next(last_grant_q, k);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a packet owns the output until its tlast beat is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
`ifdef AXIS_UART_TX_ARB_TAG_EN
                    state_d = TAG;
`else
                    state_d = PKT;
`endif
                end
            end
`ifdef AXIS_UART_TX_ARB_TAG_EN
            TAG: begin
                if (out_free) begin
                    state_d = PKT;
                end
            end
`endif
            PKT: begin
                if (beat_accept && beat_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: only the granted requester sees ready, and only in PKT.
    always_comb begin
        s_tready = '0;
        if (state_q == PKT) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_q == 3'(i)) begin
                    s_tready[i] = out_free;
                end
            end
        end
    end

    // Grant bookkeeping and the single-entry output register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_q      <= 3'd0;
            last_grant_q <= 3'(NUM_PORTS - 1);
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            m_tdata      <= '0;
        end else begin
            if ((state_q == IDLE) && pick_found) begin
                grant_q <= pick_idx;
            end
            if (beat_accept && beat_last) begin
                last_grant_q <= grant_q;
            end
            if (beat_accept) begin
                m_tvalid <= 1'b1;
                m_tdata  <= data_arr[grant_q];
                m_tlast  <= beat_last;
            end else if (tag_load) begin
                m_tvalid <= 1'b1;
                m_tdata  <= {{(DATA_WIDTH-3){1'b0}}, grant_q};
                m_tlast  <= 1'b0;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// tb_axis_uart_tx_arbiter
// Directed bench for axis_uart_tx_arbiter. A packet-level model predicts the
// merged beat order by round-robin over the queued packets; a compare process
// checks every output transfer, held beat, ready owner and load latency.

module tb_axis_uart_tx_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
`ifdef AXIS_UART_TX_ARB_TAG_EN
    localparam int HS = 1;
`else
    localparam int HS = 0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic [NP-1:0]      s_tvalid = '0;
    logic [NP-1:0]      s_tlast = '0;
    logic [NP*DW-1:0]   s_tdata = '0;
    logic [NP-1:0]      s_tready;
    logic               m_tvalid;
    logic               m_tlast;
    logic [DW-1:0]      m_tdata;
    logic               m_tready = 1'b0;
    logic [2:0]         grant_idx;

    int errors = 0;
    int checks = 0;

    // Model state.
    beat_t       pend [NP][$];
    beat_t       src_beats [NP][$];
    beat_t       exp_out [$];
    int          exp_in [$];
    int          m_last = NP - 1;
    logic [NP-1:0] src_en = '0;
    logic [NP-1:0] fire = '0;

    logic [31:0] log_data [$];
    logic        log_last [$];
    int          log_port [$];

    int exp_ports [5] = '{0, 1, 2, 3, 0};

    axis_uart_tx_arbiter #(
        .NUM_PORTS(NP),
        .DATA_WIDTH(DW)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_tvalid(s_tvalid),
        .s_tlast(s_tlast),
        .s_tdata(s_tdata),
        .s_tready(s_tready),
        .m_tvalid(m_tvalid),
        .m_tlast(m_tlast),
        .m_tdata(m_tdata),
        .m_tready(m_tready),
        .grant_idx(grant_idx)
    );

    always #5 aclk = ~aclk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Queue one packet of n beats (base, base+1, ...) on port p.
    task automatic add_packet(input int p, input int n, input logic [31:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + 32'(i);
            b.last = (i == n - 1);
            pend[p].push_back(b);
            src_beats[p].push_back(b);
        end
    endtask

    // Round-robin over every pending packet, producing the output beat order.
    task automatic predict();
        int    p;
        int    c;
        beat_t b;
        bit    done;
        forever begin
            p = -1;
            for (int k = 1; k <= NP; k++) begin
                c = (m_last + k) % NP;
                if (p < 0 && pend[c].size() > 0) p = c;
            end
            if (p < 0) break;
            if (HS == 1) begin
                b.data = 32'(p);
                b.last = 1'b0;
                exp_out.push_back(b);
            end
            done = 1'b0;
            while (!done && pend[p].size() > 0) begin
                b = pend[p].pop_front();
                exp_out.push_back(b);
                exp_in.push_back(p);
                done = b.last;
            end
            m_last = p;
        end
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_last.delete();
        log_port.delete();
    endtask

    task automatic flush_model();
        for (int p = 0; p < NP; p++) begin
            pend[p].delete();
            src_beats[p].delete();
        end
        exp_out.delete();
        exp_in.delete();
        src_en = '0;
        m_last = NP - 1;
    endtask

    task automatic reset_dut();
        @(posedge aclk); #2;
        aresetn = 1'b0;
        flush_model();
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
    endtask

    // Run until everything predicted has come out, bounded.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        m_tready = 1'b1;
        while ((exp_out.size() != 0 || m_tvalid) && n < 300) begin
            @(posedge aclk); #2;
            n++;
        end
        checks++;
        if (exp_out.size() != 0 || exp_in.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s drain: got %0d beats outstanding expected 0", name, exp_out.size());
            exp_out.delete();
            exp_in.delete();
        end
        src_en = '0;
    endtask

    // Source drivers present the head beat of each enabled port queue.
    initial begin
        forever begin
            @(posedge aclk); #1;
            for (int p = 0; p < NP; p++) begin
                if (fire[p] && src_beats[p].size() > 0) void'(src_beats[p].pop_front());
                if (src_en[p] && src_beats[p].size() > 0) begin
                    s_tvalid[p]         = 1'b1;
                    s_tdata[p*DW +: DW] = src_beats[p][0].data;
                    s_tlast[p]          = src_beats[p][0].last;
                end else begin
                    s_tvalid[p]         = 1'b0;
                    s_tdata[p*DW +: DW] = '0;
                    s_tlast[p]          = 1'b0;
                end
            end
        end
    end

    // Compare process: every falling edge, check DUT outputs against the model.
    initial begin
        logic        prev_hold;
        logic [31:0] prev_data;
        logic        prev_last;
        logic        prev_fire;
        logic [31:0] fire_data;
        logic        fire_last;
        beat_t       b;
        prev_hold = 1'b0;
        prev_fire = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        fire_data = '0;
        fire_last = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_hold = 1'b0;
                prev_fire = 1'b0;
                fire      = '0;
            end else begin
                if (prev_hold) begin
                    check_output("hold_valid", 32'(m_tvalid), 32'd1);
                    check_output("hold_data", m_tdata, prev_data);
                    check_output("hold_last", 32'(m_tlast), 32'(prev_last));
                end
                if (prev_fire) begin
                    check_output("latency_valid", 32'(m_tvalid), 32'd1);
                    check_output("latency_data", m_tdata, fire_data);
                    check_output("latency_last", 32'(m_tlast), 32'(fire_last));
                end
                if (m_tvalid && !m_tready) begin
                    check_output("stall_ready", 32'(s_tready), 32'd0);
                end
                if (s_tready != '0) begin
                    if (exp_in.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL ready_owner: got 0x%0h expected no ready", s_tready);
                    end else begin
                        check_output("ready_owner", 32'(s_tready), 32'(1) << exp_in[0]);
                    end
                end
                if (m_tvalid && m_tready) begin
                    if (exp_out.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got 0x%08h expected none", m_tdata);
                    end else begin
                        b = exp_out.pop_front();
                        check_output("out_data", m_tdata, b.data);
                        check_output("out_last", 32'(m_tlast), 32'(b.last));
                    end
                    log_data.push_back(m_tdata);
                    log_last.push_back(m_tlast);
                    log_port.push_back(int'(grant_idx));
                end
                prev_fire = 1'b0;
                fire      = '0;
                for (int p = 0; p < NP; p++) begin
                    if (s_tvalid[p] && s_tready[p]) begin
                        fire[p]   = 1'b1;
                        prev_fire = 1'b1;
                        fire_data = s_tdata[p*DW +: DW];
                        fire_last = s_tlast[p];
                        if (exp_in.size() > 0) void'(exp_in.pop_front());
                    end
                end
                prev_hold = m_tvalid && !m_tready;
                prev_data = m_tdata;
                prev_last = m_tlast;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int n;
        bit ok;

        // Reset values while aresetn is held low.
        repeat (2) @(negedge aclk);
        check_output("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check_output("rst_m_tlast", 32'(m_tlast), 32'd0);
        check_output("rst_m_tdata", m_tdata, 32'd0);
        check_output("rst_s_tready", 32'(s_tready), 32'd0);
        check_output("rst_grant_idx", 32'(grant_idx), 32'd0);
        @(posedge aclk); #2;
        aresetn = 1'b1;

        // Ports 0 and 2, one-beat packets.
        clear_logs();
        add_packet(0, 1, 32'h1111_1111);
        add_packet(2, 1, 32'h2222_2222);
        predict();
        m_tready = 1'b1;
        src_en   = 4'b0101;
        wait_drain("two_ports");
        check_output("two_ports_first", log_data[HS], 32'h1111_1111);
        check_output("two_ports_first_last", 32'(log_last[HS]), 32'd1);
        check_output("two_ports_second", log_data[1 + 2*HS], 32'h2222_2222);
        check_output("two_ports_second_last", 32'(log_last[1 + 2*HS]), 32'd1);
        check_output("grant_hold_idle", 32'(grant_idx), 32'd2);

        // Port 1 three-beat packet; port 3 becomes valid a cycle later.
        reset_dut();
        clear_logs();
        add_packet(1, 3, 32'h1000_0001);
        add_packet(3, 1, 32'h3333_3333);
        predict();
        m_tready = 1'b1;
        src_en   = 4'b0010;
        @(posedge aclk); #2;
        src_en   = 4'b1010;
        wait_drain("contiguous");
        check_output("contig_b0", log_data[HS], 32'h1000_0001);
        check_output("contig_b1", log_data[HS + 1], 32'h1000_0002);
        check_output("contig_b2", log_data[HS + 2], 32'h1000_0003);
        check_output("contig_b2_last", 32'(log_last[HS + 2]), 32'd1);
        check_output("contig_b0_last", 32'(log_last[HS]), 32'd0);
        check_output("contig_p3", log_data[3 + 2*HS], 32'h3333_3333);
        check_output("contig_p3_port", 32'(log_port[3 + 2*HS]), 32'd3);

        // Back-pressure: hold m_tready low for five cycles on 0xDEADBEEF.
        clear_logs();
        add_packet(0, 2, 32'h0);
        pend[0].delete();
        src_beats[0].delete();
        begin
            beat_t b;
            b.data = 32'hDEAD_BEEF; b.last = 1'b0;
            pend[0].push_back(b); src_beats[0].push_back(b);
            b.data = 32'h1234_5678; b.last = 1'b1;
            pend[0].push_back(b); src_beats[0].push_back(b);
        end
        predict();
        @(posedge aclk); #2;
        m_tready = 1'b0;
        src_en   = 4'b0001;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(posedge aclk); #2;
            n++;
            if (m_tvalid && m_tdata == 32'hDEAD_BEEF) begin
                m_tready = 1'b0;
                ok = 1'b1;
            end else begin
                m_tready = m_tvalid;
            end
        end
        check_output("stall_reached", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check_output("stall_data", m_tdata, 32'hDEAD_BEEF);
            check_output("stall_valid", 32'(m_tvalid), 32'd1);
            check_output("stall_s_tready", 32'(s_tready), 32'd0);
        end
        @(posedge aclk); #2;
        wait_drain("stall");
        check_output("stall_out0", log_data[HS], 32'hDEAD_BEEF);
        check_output("stall_out1", log_data[HS + 1], 32'h1234_5678);
        check_output("stall_out1_last", 32'(log_last[HS + 1]), 32'd1);

        // All four ports continuously valid: grant order wraps 0,1,2,3,0.
        reset_dut();
        clear_logs();
        add_packet(0, 1, 32'hA000_0000);
        add_packet(1, 1, 32'hA000_0001);
        add_packet(2, 1, 32'hA000_0002);
        add_packet(3, 1, 32'hA000_0003);
        add_packet(0, 1, 32'hA000_0010);
        predict();
        m_tready = 1'b1;
        src_en   = 4'b1111;
        wait_drain("wrap");
        for (int i = 0; i < 5; i++) begin
            check_output("wrap_port", 32'(log_port[i*(1 + HS) + HS]), 32'(exp_ports[i]));
        end
        check_output("wrap_last_data", log_data[4*(1 + HS) + HS], 32'hA000_0010);

        // Reset during beat 2 of a four-beat packet.
        clear_logs();
        add_packet(2, 4, 32'h2000_0001);
        predict();
        m_tready = 1'b1;
        src_en   = 4'b0100;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge aclk);
            n++;
            if (m_tvalid && m_tdata == 32'h2000_0002) ok = 1'b1;
        end
        check_output("midpkt_reached", 32'(ok), 32'd1);
        #1;
        aresetn = 1'b0;
        #1;
        check_output("midpkt_m_tvalid", 32'(m_tvalid), 32'd0);
        check_output("midpkt_m_tdata", m_tdata, 32'd0);
        check_output("midpkt_s_tready", 32'(s_tready), 32'd0);
        check_output("midpkt_grant_idx", 32'(grant_idx), 32'd0);
        flush_model();
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        clear_logs();
        add_packet(3, 1, 32'h0B0B_0B0B);
        add_packet(0, 1, 32'h0A0A_0A0A);
        predict();
        src_en = 4'b1001;
        wait_drain("after_reset");
        check_output("after_reset_port", 32'(log_port[HS]), 32'd0);
        check_output("after_reset_data", log_data[HS], 32'h0A0A_0A0A);

`ifdef AXIS_UART_TX_ARB_TAG_EN
        // Header beat carries the granted index ahead of the packet.
        clear_logs();
        add_packet(2, 1, 32'hCAFE_F00D);
        predict();
        m_tready = 1'b1;
        src_en   = 4'b0100;
        wait_drain("tag");
        check_output("tag_header", log_data[0], 32'h0000_0002);
        check_output("tag_header_last", 32'(log_last[0]), 32'd0);
        check_output("tag_payload", log_data[1], 32'hCAFE_F00D);
        check_output("tag_payload_last", 32'(log_last[1]), 32'd1);
`endif

        repeat (3) @(posedge aclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
